// File: rtl/decode_operand_stage.sv
// Decode / operand-fetch stage: reads two operands from the register bank and registers
// the decoded instruction for execute. A per-register pending scoreboard stalls RAW/WAW hazards.
module decode_operand_stage #(
  parameter int         STALL_CNT_W = 16,
  parameter logic [5:0] WB_OPC_MAX  = 6'h10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  output logic [3:0]             read_reg1,
  output logic [3:0]             read_reg2,
  input  logic [31:0]            data_out1,
  input  logic [31:0]            data_out2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [5:0]             out_opcode,
  output logic [3:0]             out_rd,
  output logic [31:0]            out_a,
  output logic [31:0]            out_b,
  output logic [31:0]            out_imm,
  output logic                   out_writes_rd,
  input  logic                   wb_valid,
  input  logic [3:0]             wb_reg,
  input  logic                   flush,
  output logic [STALL_CNT_W-1:0] stall_count
);

  function automatic logic writes_rd_f(input logic [5:0] opc, input logic [3:0] rd);
    return (opc <= WB_OPC_MAX) && (rd != 4'd0);
  endfunction

  function automatic logic signed [31:0] sext_imm(input logic [13:0] imm);
    return {{18{imm[13]}}, imm};
  endfunction

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [5:0]              opc_in;
  logic [3:0]              rd_in;
  logic [3:0]              rs_in;
  logic [3:0]              rt_in;
  logic                    wr_in;
  logic                    hazard;
  logic                    accept;
  logic [15:0]             pending;
  logic [15:0]             pending_nxt;
  logic [STALL_CNT_W-1:0]  stall_cnt;

  logic                    vld_p0;
  logic [5:0]              opc_p0;
  logic [3:0]              rd_p0;
  logic signed [31:0]      a_p0;
  logic signed [31:0]      b_p0;
  logic signed [31:0]      imm_p0;
  logic                    wr_p0;

  assign opc_in    = in_instr[31:26];
  assign rd_in     = in_instr[25:22];
  assign rs_in     = in_instr[21:18];
  assign rt_in     = in_instr[17:14];
  assign wr_in     = writes_rd_f(opc_in, rd_in);
  assign read_reg1 = rs_in;
  assign read_reg2 = rt_in;

  assign hazard   = pending[rs_in] | pending[rt_in] | (wr_in & pending[rd_in]);
  assign in_ready = ~rst & ~flush & ~hazard & (~vld_p0 | out_ready);
  assign accept   = in_valid & in_ready;

  // Order matters: a set from a new accept overrides any clear on the same index.
  always_comb begin
    pending_nxt = pending;
    if (wb_valid)
      pending_nxt[wb_reg] = 1'b0;
    if (flush && vld_p0 && wr_p0)
      pending_nxt[rd_p0] = 1'b0;
    if (accept && wr_in)
      pending_nxt[rd_in] = 1'b1;
  end

  // ---- stage p0: decoded instruction and operands held for execute ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0    <= 1'b0;
      pending   <= '0;
      stall_cnt <= '0;
      opc_p0    <= '0;
      rd_p0     <= '0;
      a_p0      <= '0;
      b_p0      <= '0;
      imm_p0    <= '0;
      wr_p0     <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (in_valid && hazard && !flush)
        stall_cnt <= sat_inc(stall_cnt);
      if (accept) begin
        vld_p0 <= 1'b1;
        opc_p0 <= opc_in;
        rd_p0  <= rd_in;
        a_p0   <= data_out1;
        b_p0   <= data_out2;
        imm_p0 <= sext_imm(in_instr[13:0]);
        wr_p0  <= wr_in;
      end else if (flush || out_ready) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign out_valid     = vld_p0;
  assign out_opcode    = opc_p0;
  assign out_rd        = rd_p0;
  assign out_a         = a_p0;
  assign out_b         = b_p0;
  assign out_imm       = imm_p0;
  assign out_writes_rd = wr_p0;
  assign stall_count   = stall_cnt;

endmodule

// File: tb/tb_decode_operand_stage.sv
// Scoreboard bench for decode_operand_stage with a behavioural 16x32 register bank.
module tb_decode_operand_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, data_out1, data_out2;
  logic [3:0]  read_reg1, read_reg2, out_rd, wb_reg;
  logic [5:0]  out_opcode;
  logic [31:0] out_a, out_b, out_imm, wb_data;
  logic        out_writes_rd, wb_valid, flush;
  logic [15:0] stall_count;

  typedef struct {
    logic [5:0]  op;
    logic [3:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        wr;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   w;

  logic [31:0] bank [16];

  always #5 clk = ~clk;

  decode_operand_stage #(.STALL_CNT_W(16), .WB_OPC_MAX(6'h10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .data_out1(data_out1), .data_out2(data_out2),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode), .out_rd(out_rd),
    .out_a(out_a), .out_b(out_b), .out_imm(out_imm), .out_writes_rd(out_writes_rd),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush), .stall_count(stall_count)
  );

  assign data_out1 = bank[read_reg1];
  assign data_out2 = bank[read_reg2];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) bank[i] <= 32'(i * 10);
    end else if (wb_valid) begin
      bank[wb_reg] <= wb_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [3:0] rt,
                                      input logic [13:0] imm);
    return {op, rd, rs, rt, imm};
  endfunction

  function automatic exp_t mk(input logic [5:0] op, input logic [3:0] rd, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] imm, input logic wr);
    exp_t e;
    e.op = op; e.rd = rd; e.a = a; e.b = b; e.imm = imm; e.wr = wr;
    return e;
  endfunction

  // Monitor: every consumed output is matched against the oldest expected entry.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && !flush && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got opcode %h rd %h with nothing expected", out_opcode, out_rd);
      end else begin
        e = q.pop_front();
        chk("out_opcode", {26'd0, out_opcode}, {26'd0, e.op});
        chk("out_rd", {28'd0, out_rd}, {28'd0, e.rd});
        chk("out_a", out_a, e.a);
        chk("out_b", out_b, e.b);
        chk("out_imm", out_imm, e.imm);
        chk("out_writes_rd", {31'd0, out_writes_rd}, {31'd0, e.wr});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; holds in_valid until accepted or the budget runs out.
  task automatic issue(input logic [31:0] instr, input bit push, input exp_t e, output int waited);
    in_instr = instr;
    in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue_timeout: instr %h never accepted, in_ready %b required 1", instr, in_ready);
    end else if (push) begin
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    wb_valid = 1'b0; wb_reg = '0; wb_data = '0; flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("in_ready_in_rst", {31'd0, in_ready}, 32'd0);
    chk("out_valid_in_rst", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_imm", out_imm, 32'd0);
    chk("rst_stall_count", {16'd0, stall_count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD r3 = r1 + r2
    out_ready = 1'b1;
    tick();
    issue(32'h04C48000, 1'b1, mk(6'd1, 4'd3, 32'd10, 32'd20, 32'd0, 1'b1), w);

    // RAW on r3, cleared by writeback of 777
    in_instr = enc(6'd2, 4'd4, 4'd3, 4'd0, 14'd0);
    in_valid = 1'b1;
    @(negedge clk);
    chk("out_valid_after_add", {31'd0, out_valid}, 32'd1);
    chk("raw_stall_ready", {31'd0, in_ready}, 32'd0);
    chk("raw_stall_count0", {16'd0, stall_count}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    wb_valid = 1'b1; wb_reg = 4'd3; wb_data = 32'd777;
    @(negedge clk);
    chk("raw_stall_count3", {16'd0, stall_count}, 32'd3);
    chk("ready_during_wb", {31'd0, in_ready}, 32'd0);
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_wb", {31'd0, in_ready}, 32'd1);
    if (in_ready) q.push_back(mk(6'd2, 4'd4, 32'd777, 32'd0, 32'd0, 1'b1));
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("raw_stall_count4", {16'd0, stall_count}, 32'd4);
    tick();

    // Backpressure: A held, B waits
    out_ready = 1'b0;
    issue(enc(6'h11, 4'd6, 4'd1, 4'd2, 14'd0), 1'b1, mk(6'h11, 4'd6, 32'd10, 32'd20, 32'd0, 1'b0), w);
    in_instr = enc(6'd4, 4'd7, 4'd1, 4'd2, 14'h2000);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_opcode", {26'd0, out_opcode}, 32'h11);
      chk("bp_hold_a", out_a, 32'd10);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    if (in_ready) q.push_back(mk(6'd4, 4'd7, 32'd10, 32'd20, 32'hFFFFE000, 1'b1));
    tick();
    in_valid = 1'b0;
    issue(enc(6'd5, 4'd0, 4'd1, 4'd2, 14'h1FFF), 1'b1, mk(6'd5, 4'd0, 32'd10, 32'd20, 32'h00001FFF, 1'b0), w);
    tick();

    // Flush a held writer of r5, then read r5 and r0 without stalling
    out_ready = 1'b0;
    issue(enc(6'd1, 4'd5, 4'd1, 4'd2, 14'd0), 1'b0, mk(6'd0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0), w);
    flush = 1'b1;
    @(negedge clk);
    chk("in_ready_flush", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_drops_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    tick();
    issue(enc(6'd1, 4'd8, 4'd5, 4'd5, 14'd0), 1'b1, mk(6'd1, 4'd8, 32'd50, 32'd50, 32'd0, 1'b1), w);
    chk("r5_no_stall", w, 32'd0);
    issue(enc(6'd1, 4'd0, 4'd1, 4'd2, 14'd0), 1'b1, mk(6'd1, 4'd0, 32'd10, 32'd20, 32'd0, 1'b0), w);
    issue(enc(6'd1, 4'd9, 4'd0, 4'd0, 14'd0), 1'b1, mk(6'd1, 4'd9, 32'd0, 32'd0, 32'd0, 1'b1), w);
    chk("r0_no_stall", w, 32'd0);
    chk("stall_count_kept", {16'd0, stall_count}, 32'd4);
    tick();

    // Reset while a writer of r10 is held and a reader of r10 stalls
    out_ready = 1'b0;
    issue(enc(6'd1, 4'd10, 4'd1, 4'd2, 14'd0), 1'b0, mk(6'd0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0), w);
    in_instr = enc(6'd1, 4'd11, 4'd10, 4'd0, 14'd0);
    in_valid = 1'b1;
    @(negedge clk);
    chk("stall_before_rst", {31'd0, in_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("stall_count5", {16'd0, stall_count}, 32'd5);
    chk("held_before_rst", {31'd0, out_valid}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_opcode", {26'd0, out_opcode}, 32'd0);
    chk("mid_rst_out_rd", {28'd0, out_rd}, 32'd0);
    chk("mid_rst_out_a", out_a, 32'd0);
    chk("mid_rst_out_b", out_b, 32'd0);
    chk("mid_rst_out_imm", out_imm, 32'd0);
    chk("mid_rst_writes_rd", {31'd0, out_writes_rd}, 32'd0);
    chk("mid_rst_stall_count", {16'd0, stall_count}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);

    chk("scoreboard_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
